// File: rtl/transfer_execute_wb.sv
// Execute -> Write-Back pipeline register for the dual-issue core.
// Captures both issue slots' write enables, destinations, unit selects and raw
// unit results. Write-Back does the final per-slot data selection.
//
// Optional feature macro: TRANSFER_EXECUTE_WB_RD0_SUPPRESS_EN
//   defined   -> a slot targeting x0 never writes back (reg_write forced to 0)
//   undefined -> rd = 0 receives no special treatment
module transfer_execute_wb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              reg_write1_execute,
    input  logic              reg_write2_execute,
    input  logic [RD_W-1:0]   rd1_execute,
    input  logic [RD_W-1:0]   rd2_execute,
    input  logic [SEL_W-1:0]  au_mul_lsu1,
    input  logic [SEL_W-1:0]  au_mul_lsu2,
    input  logic [DATA_W-1:0] au1_result,
    input  logic [DATA_W-1:0] au2_result,
    input  logic [DATA_W-1:0] mul1_result,
    input  logic [DATA_W-1:0] mul2_result,
    input  logic [DATA_W-1:0] lsu_result,
    output logic              reg_write1_wb,
    output logic              reg_write2_wb,
    output logic [RD_W-1:0]   rd1_wb,
    output logic [RD_W-1:0]   rd2_wb,
    output logic [SEL_W-1:0]  au_mul_lsu1_wb,
    output logic [SEL_W-1:0]  au_mul_lsu2_wb,
    output logic [DATA_W-1:0] au1_wb,
    output logic [DATA_W-1:0] au2_wb,
    output logic [DATA_W-1:0] mul1_wb,
    output logic [DATA_W-1:0] mul2_wb,
    output logic [DATA_W-1:0] lsu_wb
);

    // Bit position of the LSU request inside a unit-select code.
    localparam int unsigned LsuBit = 2;

    logic              reg_write1_d, reg_write1_q;
    logic              reg_write2_d, reg_write2_q;
    logic [RD_W-1:0]   rd1_q, rd2_q;
    logic [SEL_W-1:0]  sel1_q, sel2_q;
    logic [DATA_W-1:0] au1_q, au2_q, mul1_q, mul2_q, lsu_q;

    logic sel1_onehot, sel2_onehot, lsu_conflict;
    logic rd1_zero, rd2_zero;

    // Qualify the raw write enables: select must be one-hot, only one slot may own the LSU.
    always_comb begin
        sel1_onehot  = (au_mul_lsu1 != '0) &&
                       ((au_mul_lsu1 & (au_mul_lsu1 - SEL_W'(1))) == '0);
        sel2_onehot  = (au_mul_lsu2 != '0) &&
                       ((au_mul_lsu2 & (au_mul_lsu2 - SEL_W'(1))) == '0);
        // Slot 1 is older in program order, so it wins the shared LSU.
        lsu_conflict = au_mul_lsu1[LsuBit] & au_mul_lsu2[LsuBit];
`ifdef TRANSFER_EXECUTE_WB_RD0_SUPPRESS_EN
        rd1_zero     = (rd1_execute == '0);
        rd2_zero     = (rd2_execute == '0);
`else
        rd1_zero     = 1'b0;
        rd2_zero     = 1'b0;
`endif
        reg_write1_d = reg_write1_execute & sel1_onehot & ~rd1_zero;
        reg_write2_d = reg_write2_execute & sel2_onehot & ~lsu_conflict & ~rd2_zero;
    end

    // Pipeline register: synchronous reset beats stall, stall beats capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_write1_q <= 1'b0;
            reg_write2_q <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            sel1_q       <= '0;
            sel2_q       <= '0;
            au1_q        <= '0;
            au2_q        <= '0;
            mul1_q       <= '0;
            mul2_q       <= '0;
            lsu_q        <= '0;
        end else if (!stall) begin
            reg_write1_q <= reg_write1_d;
            reg_write2_q <= reg_write2_d;
            rd1_q        <= rd1_execute;
            rd2_q        <= rd2_execute;
            sel1_q       <= au_mul_lsu1;
            sel2_q       <= au_mul_lsu2;
            au1_q        <= au1_result;
            au2_q        <= au2_result;
            mul1_q       <= mul1_result;
            mul2_q       <= mul2_result;
            lsu_q        <= lsu_result;
        end
    end

    // Outputs come straight from the flops; no input-to-output path.
    always_comb begin
        reg_write1_wb  = reg_write1_q;
        reg_write2_wb  = reg_write2_q;
        rd1_wb         = rd1_q;
        rd2_wb         = rd2_q;
        au_mul_lsu1_wb = sel1_q;
        au_mul_lsu2_wb = sel2_q;
        au1_wb         = au1_q;
        au2_wb         = au2_q;
        mul1_wb        = mul1_q;
        mul2_wb        = mul2_q;
        lsu_wb         = lsu_q;
    end

endmodule

// File: tb/tb_transfer_execute_wb.sv
// Directed bench for transfer_execute_wb: reset, capture, stall hold,
// reset-over-stall, select validity, LSU conflict and the optional x0 rule.
module tb_transfer_execute_wb;

    logic        clk = 1'b0;
    logic        rst_n, stall;
    logic        rw1, rw2;
    logic [4:0]  rd1, rd2;
    logic [2:0]  sel1, sel2;
    logic [31:0] au1, au2, mul1, mul2, lsu;

    logic        rw1_wb, rw2_wb;
    logic [4:0]  rd1_wb, rd2_wb;
    logic [2:0]  sel1_wb, sel2_wb;
    logic [31:0] au1_wb, au2_wb, mul1_wb, mul2_wb, lsu_wb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    transfer_execute_wb dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .reg_write1_execute (rw1),
        .reg_write2_execute (rw2),
        .rd1_execute        (rd1),
        .rd2_execute        (rd2),
        .au_mul_lsu1        (sel1),
        .au_mul_lsu2        (sel2),
        .au1_result         (au1),
        .au2_result         (au2),
        .mul1_result        (mul1),
        .mul2_result        (mul2),
        .lsu_result         (lsu),
        .reg_write1_wb      (rw1_wb),
        .reg_write2_wb      (rw2_wb),
        .rd1_wb             (rd1_wb),
        .rd2_wb             (rd2_wb),
        .au_mul_lsu1_wb     (sel1_wb),
        .au_mul_lsu2_wb     (sel2_wb),
        .au1_wb             (au1_wb),
        .au2_wb             (au2_wb),
        .mul1_wb            (mul1_wb),
        .mul2_wb            (mul2_wb),
        .lsu_wb             (lsu_wb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rw1"},  32'(rw1_wb),  32'h0);
        check({tag, " rw2"},  32'(rw2_wb),  32'h0);
        check({tag, " rd1"},  32'(rd1_wb),  32'h0);
        check({tag, " rd2"},  32'(rd2_wb),  32'h0);
        check({tag, " sel1"}, 32'(sel1_wb), 32'h0);
        check({tag, " sel2"}, 32'(sel2_wb), 32'h0);
        check({tag, " au1"},  au1_wb,       32'h0);
        check({tag, " au2"},  au2_wb,       32'h0);
        check({tag, " mul1"}, mul1_wb,      32'h0);
        check({tag, " mul2"}, mul2_wb,      32'h0);
        check({tag, " lsu"},  lsu_wb,       32'h0);
    endtask

    initial begin
        // Reset with arbitrary inputs present.
        rst_n = 1'b0; stall = 1'b0;
        rw1 = 1'b1; rw2 = 1'b1; rd1 = 5'd17; rd2 = 5'd22;
        sel1 = 3'b001; sel2 = 3'b010;
        au1 = 32'h1111_1111; au2 = 32'h2222_2222;
        mul1 = 32'h3333_3333; mul2 = 32'h4444_4444; lsu = 32'h5555_5555;
        step();
        step();
        check_all_zero("reset");

        // First capture.
        rst_n = 1'b1;
        rw1 = 1'b1; rd1 = 5'd5; sel1 = 3'b001; au1 = 32'hDEAD_BEEF;
        rw2 = 1'b1; rd2 = 5'd7; sel2 = 3'b010; mul2 = 32'h1234_5678;
        step();
        check("cap rw1",  32'(rw1_wb),  32'h1);
        check("cap rd1",  32'(rd1_wb),  32'd5);
        check("cap sel1", 32'(sel1_wb), 32'h1);
        check("cap au1",  au1_wb,       32'hDEAD_BEEF);
        check("cap rw2",  32'(rw2_wb),  32'h1);
        check("cap rd2",  32'(rd2_wb),  32'd7);
        check("cap sel2", 32'(sel2_wb), 32'h2);
        check("cap mul2", mul2_wb,      32'h1234_5678);
        check("cap lsu",  lsu_wb,       32'h5555_5555);

        // Stall for three edges while inputs move.
        stall = 1'b1;
        mul2 = 32'hAAAA_5555; rd2 = 5'd9; au1 = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall mul2", mul2_wb,      32'h1234_5678);
            check("stall rd2",  32'(rd2_wb),  32'd7);
            check("stall au1",  au1_wb,       32'hDEAD_BEEF);
        end
        stall = 1'b0;
        step();
        check("unstall mul2", mul2_wb,     32'hAAAA_5555);
        check("unstall rd2",  32'(rd2_wb), 32'd9);
        check("unstall au1",  au1_wb,      32'h0BAD_F00D);

        // Reset wins over stall.
        stall = 1'b1; rst_n = 1'b0;
        step();
        check_all_zero("rst+stall");
        stall = 1'b0; rst_n = 1'b1;

        // Invalid selects.
        rw1 = 1'b1; rd1 = 5'd6; sel1 = 3'b011;
        rw2 = 1'b1; rd2 = 5'd8; sel2 = 3'b111;
        step();
        check("inv011 rw1",  32'(rw1_wb),  32'h0);
        check("inv011 sel1", 32'(sel1_wb), 32'h3);
        check("inv011 rd1",  32'(rd1_wb),  32'd6);
        check("inv111 rw2",  32'(rw2_wb),  32'h0);
        check("inv111 sel2", 32'(sel2_wb), 32'h7);
        sel1 = 3'b000; sel2 = 3'b010;
        step();
        check("inv000 rw1", 32'(rw1_wb), 32'h0);
        check("valid rw2",  32'(rw2_wb), 32'h1);

        // LSU conflict: slot 1 keeps it, slot 2 loses its write.
        sel1 = 3'b100; sel2 = 3'b100; rw1 = 1'b1; rw2 = 1'b1;
        rd1 = 5'd3; rd2 = 5'd4; lsu = 32'hCAFE_F00D;
        step();
        check("lsu rw1", 32'(rw1_wb), 32'h1);
        check("lsu rw2", 32'(rw2_wb), 32'h0);
        check("lsu data", lsu_wb,     32'hCAFE_F00D);
        check("lsu rd2", 32'(rd2_wb), 32'd4);

        // Only slot 2 on the LSU: no conflict.
        sel1 = 3'b001;
        step();
        check("lsu2only rw1", 32'(rw1_wb), 32'h1);
        check("lsu2only rw2", 32'(rw2_wb), 32'h1);

        // Write-enable low stays low even with a valid select.
        rw1 = 1'b0;
        step();
        check("rw1 low", 32'(rw1_wb), 32'h0);

        // Destination x0.
        rw1 = 1'b1; rd1 = 5'd0; sel1 = 3'b001;
        rw2 = 1'b1; rd2 = 5'd0; sel2 = 3'b010;
        step();
`ifdef TRANSFER_EXECUTE_WB_RD0_SUPPRESS_EN
        check("x0 rw1", 32'(rw1_wb), 32'h0);
        check("x0 rw2", 32'(rw2_wb), 32'h0);
`else
        check("x0 rw1", 32'(rw1_wb), 32'h1);
        check("x0 rw2", 32'(rw2_wb), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
